// File: rtl/maze_wall_query.sv
// Neighbour-wall lookup for a mover tile against the single-port maze ROM.
// Reads up/down/left/right in four slots and publishes all flags at once.
module maze_wall_query #(
    parameter int GRID_W     = 28,
    parameter int GRID_H     = 36,
    parameter int TUNNEL_ROW = 17,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [5:0]        tileX,
    input  logic [5:0]        tileY,
    output logic              busy,
    output logic              valid,
    output logic              wallUp,
    output logic              wallDown,
    output logic              wallLeft,
    output logic              wallRight,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_data
);

    localparam logic [5:0] W_TILES = 6'(GRID_W);
    localparam logic [5:0] H_TILES = 6'(GRID_H);
    localparam logic [5:0] LAST_X  = 6'(GRID_W - 1);
    localparam logic [5:0] LAST_Y  = 6'(GRID_H - 1);
    localparam logic [5:0] T_ROW   = 6'(TUNNEL_ROW);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(GRID_W);

    typedef enum logic [2:0] {
        IDLE, S_UP, S_DN, S_LF, S_RT, S_CAP
    } state_t;

    state_t state, nextState;

    logic [5:0] qx, qy;
    logic fUp, fDn, fLf, fRt;
    logic shUp, shDn, shLf;
    logic issue, outOfRange;
    logic [5:0] ax, ay;
    logic slotForced;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        busy      = 1'b1;
        issue     = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (req) begin
                    nextState = S_UP;
                    issue     = 1'b1;
                end
            end
            S_UP:    nextState = S_DN;
            S_DN:    nextState = S_LF;
            S_LF:    nextState = S_RT;
            S_RT:    nextState = S_CAP;
            S_CAP:   nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Left/right neighbours wrap; non-tunnel edges are already forced walls.
    always_comb begin
        ax         = qx;
        ay         = qy;
        slotForced = 1'b1;
        unique case (state)
            S_UP: begin
                ay         = qy - 6'd1;
                slotForced = fUp;
            end
            S_DN: begin
                ay         = qy + 6'd1;
                slotForced = fDn;
            end
            S_LF: begin
                ax         = (qx == 6'd0) ? LAST_X : qx - 6'd1;
                slotForced = fLf;
            end
            S_RT: begin
                ax         = (qx == LAST_X) ? 6'd0 : qx + 6'd1;
                slotForced = fRt;
            end
            default: slotForced = 1'b1;
        endcase
        rom_addr = slotForced ? '0
                 : ADDR_W'(ay) * STRIDE + ADDR_W'(ax);
    end

    assign outOfRange = (tileX >= W_TILES) || (tileY >= H_TILES);

    always_ff @(posedge clk) begin
        if (reset) begin
            qx        <= '0;
            qy        <= '0;
            fUp       <= 1'b0;
            fDn       <= 1'b0;
            fLf       <= 1'b0;
            fRt       <= 1'b0;
            shUp      <= 1'b1;
            shDn      <= 1'b1;
            shLf      <= 1'b1;
            wallUp    <= 1'b1;
            wallDown  <= 1'b1;
            wallLeft  <= 1'b1;
            wallRight <= 1'b1;
            valid     <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (issue) begin
                qx  <= tileX;
                qy  <= tileY;
                fUp <= outOfRange || (tileY == 6'd0);
                fDn <= outOfRange || (tileY == LAST_Y);
                fLf <= outOfRange
                    || ((tileX == 6'd0) && (tileY != T_ROW));
                fRt <= outOfRange
                    || ((tileX == LAST_X) && (tileY != T_ROW));
            end
            // rom_data lags rom_addr by one slot.
            unique case (state)
                S_DN: shUp <= fUp | rom_data;
                S_LF: shDn <= fDn | rom_data;
                S_RT: shLf <= fLf | rom_data;
                S_CAP: begin
                    wallUp    <= shUp;
                    wallDown  <= shDn;
                    wallLeft  <= shLf;
                    wallRight <= fRt | rom_data;
                    valid     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_maze_wall_query.sv
// Bench for maze_wall_query: directed corner/tunnel/handshake cases
// plus random tiles over random mazes, against a neighbour model.
module tb_maze_wall_query;

    localparam int GW = 28;
    localparam int GH = 36;
    localparam int TROW = 17;

    logic       clk = 1'b0;
    logic       reset;
    logic       req;
    logic [5:0] tileX, tileY;
    logic       busy, valid;
    logic       wallUp, wallDown, wallLeft, wallRight;
    logic [9:0] rom_addr;
    logic       rom_data = 1'b0;

    bit rom [1024];
    int total = 0;
    int bad = 0;

    maze_wall_query dut (
        .clk(clk), .reset(reset), .req(req),
        .tileX(tileX), .tileY(tileY),
        .busy(busy), .valid(valid),
        .wallUp(wallUp), .wallDown(wallDown),
        .wallLeft(wallLeft), .wallRight(wallRight),
        .rom_addr(rom_addr), .rom_data(rom_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d",
                   tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // d: 0=up 1=down 2=left 3=right
    function automatic void nbr(input int x, input int y,
                                input int d,
                                output bit forced,
                                output int addr);
        int dx [4] = '{0, 0, -1, 1};
        int dy [4] = '{-1, 1, 0, 0};
        int nx, ny;
        forced = 1'b0;
        addr = 0;
        if (x >= GW || y >= GH) begin
            forced = 1'b1;
            return;
        end
        nx = x + dx[d];
        ny = y + dy[d];
        if (ny < 0 || ny >= GH) begin
            forced = 1'b1;
            return;
        end
        if (nx < 0 || nx >= GW) begin
            if (y == TROW) nx = (nx + GW) % GW;
            else begin
                forced = 1'b1;
                return;
            end
        end
        addr = ny * GW + nx;
    endfunction

    function automatic logic [3:0] expFlags(input int x, input int y);
        logic [3:0] r;
        bit f;
        int a;
        for (int d = 0; d < 4; d++) begin
            nbr(x, y, d, f, a);
            r[d] = f ? 1'b1 : rom[a];
        end
        return r;
    endfunction

    function automatic logic [3:0] flagsNow();
        return {wallRight, wallLeft, wallDown, wallUp};
    endfunction

    task automatic clearRom();
        for (int i = 0; i < 1024; i++) rom[i] = 1'b0;
    endtask

    // Starts at an IDLE sample point, ends in the valid cycle.
    task automatic query(input int x, input int y);
        bit f;
        int a;
        logic [3:0] ef;
        ef = expFlags(x, y);
        tileX = 6'(x);
        tileY = 6'(y);
        req = 1'b1;
        step();
        req = 1'b0;
        for (int d = 0; d < 4; d++) begin
            nbr(x, y, d, f, a);
            chk($sformatf("addr d%0d (%0d,%0d)", d, x, y),
                32'(rom_addr), f ? 0 : a);
            chk("busy_slot", 32'(busy), 1);
            chk("valid_early", 32'(valid), 0);
            step();
        end
        chk("addr_cap", 32'(rom_addr), 0);
        chk("valid_cap", 32'(valid), 0);
        step();
        chk($sformatf("valid_pulse (%0d,%0d)", x, y),
            32'(valid), 1);
        chk("busy_done", 32'(busy), 0);
        chk($sformatf("flags (%0d,%0d)", x, y),
            32'(flagsNow()), 32'(ef));
    endtask

    initial begin
        int nv;
        int n;
        int x, y, r;

        reset = 1'b1;
        req = 1'b0;
        tileX = '0;
        tileY = '0;
        clearRom();
        step();
        step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_flags", 32'(flagsNow()), 32'hF);
        chk("rst_addr", 32'(rom_addr), 0);

        // reset beats a simultaneous request
        req = 1'b1;
        tileX = 6'd3;
        tileY = 6'd3;
        step();
        reset = 1'b0;
        req = 1'b0;
        step();
        chk("rst_req_busy", 32'(busy), 0);

        rom[11 * GW + 14] = 1'b1;
        query(14, 12);
        chk("interior_flags", 32'(flagsNow()), 32'h1);
        clearRom();
        query(0, 0);
        chk("corner_flags", 32'(flagsNow()), 32'h5);
        query(0, 17);
        query(27, 17);
        query(30, 40);
        chk("oor_flags", 32'(flagsNow()), 32'hF);
        step();
        chk("valid_single", 32'(valid), 0);

        // three request cycles from IDLE yield one query
        tileX = 6'd5;
        tileY = 6'd5;
        req = 1'b1;
        nv = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            nv += int'(valid);
        end
        req = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            nv += int'(valid);
        end
        chk("req_burst_count", nv, 1);
        chk("req_burst_flags", 32'(flagsNow()), 0);

        // back-to-back: request in the valid cycle
        rom[2 * GW + 3] = 1'b1;
        query(3, 3);
        tileX = 6'd20;
        tileY = 6'd20;
        req = 1'b1;
        step();
        req = 1'b0;
        n = 1;
        while (!valid && n < 20) begin
            step();
            n++;
        end
        chk("b2b_spacing", n, 6);
        chk("b2b_flags", 32'(flagsNow()), 0);
        clearRom();
        step();

        // reset in S_LF aborts the query
        tileX = 6'd10;
        tileY = 6'd10;
        req = 1'b1;
        step();
        req = 1'b0;
        step();
        step();
        chk("midq_left_addr", 32'(rom_addr), 10 * GW + 9);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midq_busy", 32'(busy), 0);
        chk("midq_valid", 32'(valid), 0);
        chk("midq_flags", 32'(flagsNow()), 32'hF);
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            nv += int'(valid);
        end
        chk("midq_no_pulse", nv, 0);
        query(10, 10);

        for (int i = 0; i < 60; i++) begin
            for (int k = 0; k < 1024; k++)
                rom[k] = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            if (r == 0) x = 0;
            else if (r == 1) x = GW - 1;
            else x = int'($urandom_range(0, 31));
            r = int'($urandom_range(0, 9));
            if (r == 0) y = 0;
            else if (r == 1) y = TROW;
            else if (r == 2) y = GH - 1;
            else y = int'($urandom_range(0, 39));
            query(x, y);
            if ($urandom_range(0, 2) == 0) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/maze_wall_query.md
# maze_wall_query

Serializes wall lookups for a ghost or Pac-Man tile against the shared single-port maze ROM. It returns the four neighbour-wall flags (up, down, left, right) that the tile-stepping movement logic consumes. Sits between the movement blocks and the maze ROM: a mover issues a one-cycle request with its tile coordinates, and this block reads the four neighbour tiles in sequence. It then publishes all four flags at once with a valid pulse, handling grid edges and the horizontal tunnel wrap.

## Interface
Parameters:
- GRID_W, 28, maze width in tiles
- GRID_H, 36, maze height in tiles
- TUNNEL_ROW, 17, row on which left/right edges wrap
- ADDR_W, 10, ROM address width (GRID_W*GRID_H ≤ 2^ADDR_W)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  1  query request, sampled only in IDLE
- tileX  in  6  query tile X (valid 0..GRID_W-1)
- tileY  in  6  query tile Y (valid 0..GRID_H-1)
- busy  out  1  query in progress; req ignored
- valid  out  1  one-cycle pulse: wall flags updated
- wallUp  out  1  tile above is wall (1 = wall)
- wallDown  out  1  tile below is wall
- wallLeft  out  1  tile left is wall
- wallRight  out  1  tile right is wall
- rom_addr  out  ADDR_W  maze ROM address = y*GRID_W + x
- rom_data  in  1  ROM output, 1 = wall; valid the cycle after rom_addr is presented

## Operation
- States: IDLE, S_UP, S_DN, S_LF, S_RT, S_CAP.
- IDLE + req=1 → latch tileX/tileY → S_UP. In IDLE, req=0 → stay.
- Fixed sequence: S_UP→S_DN→S_LF→S_RT→S_CAP→IDLE, one state per cycle, no stalls.
- rom_addr is combinational from state and the latched coordinates:
  - S_UP: (x, y-1)
  - S_DN: (x, y+1)
  - S_LF: (x-1, y)
  - S_RT: (x+1, y)
  - IDLE/S_CAP: 0
- Shadow capture of rom_data:
  - in S_DN → up
  - in S_LF → down
  - in S_RT → left
  - in S_CAP → right
- On the S_CAP→IDLE edge, all four outputs load from the shadows simultaneously and valid=1 for one cycle. Outputs hold until the next completed query.
- Each direction's "forced" flag is computed at issue time. When forced, the slot still elapses, rom_addr=0, rom_data is ignored, and the shadow is set to 1.
- Edge rules:
  - Up with y=0 → forced wall.
  - Down with y=GRID_H-1 → forced wall.
  - Left with x=0: if y=TUNNEL_ROW, read (GRID_W-1, y); otherwise forced wall.
  - Right with x=GRID_W-1: if y=TUNNEL_ROW, read (0, y); otherwise forced wall.
- Out-of-range latched input (x≥GRID_W or y≥GRID_H): all four directions forced wall; latency unchanged.
- Address arithmetic: y*GRID_W computed at ≥ADDR_W bits, no truncation before the add.
- busy=1 in S_UP..S_CAP, 0 in IDLE.
- req while busy is dropped, not queued.

## Timing
- Reset values: state IDLE, busy=0, valid=0, all four wall flags=1 (mover stays put until the first query), shadows=1, latched coords=0.
- Latency: req sampled at edge E0 → valid high in the cycle following E5 (5 clocks), with flags updated on the same edge.
- Back-to-back: req asserted in the same cycle valid is high (state IDLE) is accepted at that edge. Throughput is 1 query per 6 cycles.
- valid is never high for two consecutive cycles.
- Reset during any state: query aborted, no valid pulse, outputs return to reset values at that edge.
- Simultaneous reset and req: reset wins, request discarded.

## Test plan
- Reset: hold reset 2 cycles → busy=0, valid=0, all wall flags=1, rom_addr=0.
- Open interior tile: ROM all 0 except (14,11)=1; req (14,12) → rom_addr sequence 322, 378, 349, 351; valid exactly 5 clocks after req. Flags: up=1, down=0, left=0, right=0.
- Corner and tunnel: ROM all 0.
  - req (0,0) → up=1, left=1, down=0, right=0.
  - req (0,17) → left-slot rom_addr=503 (27,17); left=0.
  - req (27,17) → right-slot rom_addr=476 (0,17); right=0.
- Out-of-range: req (30,40) → all flags=1 after 5 clocks; rom_addr=0 in all slots.
- Handshake: req pulses on 3 consecutive cycles from IDLE → one query. Second req asserted in the valid cycle → accepted; second valid exactly 6 cycles after the first.
- Reset mid-query: assert reset in S_LF → no valid pulse, flags=1, busy=0 next cycle. A new req then completes normally.
